dm_load_unit: RTL and testbench

//  Read-side companion to the store byte-enable path of the data memory. Accepts a load

---
 rtl/dm_load_unit.sv | 162 ++++++++++++++++
 tb/tb_dm_load_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_load_unit.sv
// Load unit for the data memory: one block-RAM read per request, lane select and
// sign/zero extension, AdEL flagging of misaligned or illegal loads.
module dm_load_unit #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_type,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = 2;
  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          typ_q, typ_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic                req_ready_q, req_ready_d;
  logic                req_illegal;

  // Byte address bits above the word index do not reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      LT_LW:   extend = w;
      LT_LH:   extend = {{16{h[15]}}, h};
      LT_LHU:  extend = {16'h0000, h};
      LT_LB:   extend = {{24{b[7]}}, b};
      LT_LBU:  extend = {24'h000000, b};
      default: extend = 32'h0000_0000;
    endcase
  endfunction

  assign req_illegal = (req_type > LT_LBU)
                    || ((req_type == LT_LW) && (req_addr[1:0] != 2'b00))
                    || (((req_type == LT_LH) || (req_type == LT_LHU)) && req_addr[0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    typ_d       = typ_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d = req_addr[1:0];
          typ_d = req_type;
          if (req_illegal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'h0000_0000;
          end else begin
            state_d    = S_READ;
            mem_en_d   = 1'b1;
            mem_addr_d = req_addr[ADDR_W+1:2];
            rsp_err_d  = 1'b0;
          end
        end
      end
      S_READ: begin
        mem_en_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Last wait edge: douta is valid this cycle.
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          rsp_data_d  = extend(mem_rdata, off_q, typ_q);
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= 2'b00;
      typ_q       <= 3'b000;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      typ_q       <= typ_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: two instances (read latency 1 and 3) on a behavioural
// block-RAM model, expected responses queued at request time and checked on handshake.
module tb_dm_load_unit;

  localparam int unsigned ADDR_W = 11;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic req_valid, rsp_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;

  logic              req_ready1, mem_en1, rsp_valid1, rsp_err1, busy1;
  logic [ADDR_W-1:0] mem_addr1;
  logic [31:0]       mem_rdata1, rsp_data1;
  logic              req_ready3, mem_en3, rsp_valid3, rsp_err3, busy3;
  logic [ADDR_W-1:0] mem_addr3;
  logic [31:0]       mem_rdata3, rsp_data3;

  logic              o_req_ready, o_mem_en, o_rsp_valid, o_rsp_err, o_busy;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_rsp_data;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] p1 [0:2];
  logic [31:0] p3 [0:2];

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_load_unit #(.ADDR_W(ADDR_W), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(req_ready1),
    .req_addr(req_addr), .req_type(req_type), .mem_en(mem_en1), .mem_addr(mem_addr1),
    .mem_rdata(mem_rdata1), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data1), .rsp_err(rsp_err1), .busy(busy1)
  );

  dm_load_unit #(.ADDR_W(ADDR_W), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(req_ready3),
    .req_addr(req_addr), .req_type(req_type), .mem_en(mem_en3), .mem_addr(mem_addr3),
    .mem_rdata(mem_rdata3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data3), .rsp_err(rsp_err3), .busy(busy3)
  );

  // Block-RAM model: address sampled on mem_en, data appears after N edges.
  always @(posedge clk) begin
    if (mem_en1) p1[0] <= mem[mem_addr1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
    if (mem_en3) p3[0] <= mem[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata1 = p1[0];
  assign mem_rdata3 = p3[2];

  assign o_req_ready = sel ? req_ready3 : req_ready1;
  assign o_mem_en    = sel ? mem_en3    : mem_en1;
  assign o_mem_addr  = sel ? mem_addr3  : mem_addr1;
  assign o_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign o_rsp_data  = sel ? rsp_data3  : rsp_data1;
  assign o_rsp_err   = sel ? rsp_err3   : rsp_err1;
  assign o_busy      = sel ? busy3      : busy1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One load: T is the cycle req_valid is presented with req_ready high.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] exp_d, input logic exp_e,
                          input logic [ADDR_W-1:0] exp_maddr, input int exp_lat,
                          input int hold);
    int n;
    int en_cnt;
    int en_cyc;
    logic [31:0] d0;
    exp_t e;
    @(posedge clk); #1;
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_type  = typ;
    rsp_ready = 1'b0;
    sb.push_back('{d: exp_d, e: exp_e});
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; en_cnt = 0; en_cyc = 0;
    while (n < 40) begin
      if (o_mem_en) begin
        en_cnt++;
        en_cyc = n;
        if (n == 1) chk("mem_addr", 32'(o_mem_addr), 32'(exp_maddr));
      end
      if (o_rsp_valid) break;
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(exp_lat));
    chk("mem_en_count", 32'(en_cnt), exp_e ? 32'd0 : 32'd1);
    if (!exp_e) chk("mem_en_cycle", 32'(en_cyc), 32'd1);
    d0 = o_rsp_data;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_data", o_rsp_data, d0);
      chk("hold_ready", 32'(o_req_ready), 32'd0);
      chk("hold_busy", 32'(o_busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    if (o_rsp_valid) begin
      chk("sb_nonempty", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_data", o_rsp_data, e.d);
        chk("rsp_err", 32'(o_rsp_err), 32'(e.e));
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_valid", 32'(o_rsp_valid), 32'd0);
    chk("post_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      p1[i] = 32'h0;
      p3[i] = 32'h0;
    end
    mem[11'h004] = 32'h8899_AABB;
    mem[11'h008] = 32'h1234_5678;
    mem[11'h1FF] = 32'hCAFE_F00D;
    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = 32'h0; req_type = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_data", o_rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b1;

    // Legal loads, read latency 1
    run_load(32'h10, 3'b000, 32'h8899_AABB, 1'b0, 11'h004, 3, 0);
    run_load(32'h13, 3'b011, 32'hFFFF_FF88, 1'b0, 11'h004, 3, 0);
    run_load(32'h12, 3'b100, 32'h0000_0099, 1'b0, 11'h004, 3, 0);
    run_load(32'h12, 3'b001, 32'hFFFF_8899, 1'b0, 11'h004, 3, 0);
    run_load(32'h10, 3'b010, 32'h0000_AABB, 1'b0, 11'h004, 3, 0);
    run_load(32'h10, 3'b011, 32'hFFFF_FFBB, 1'b0, 11'h004, 3, 0);
    run_load(32'h11, 3'b100, 32'h0000_00AA, 1'b0, 11'h004, 3, 0);
    run_load(32'h10, 3'b001, 32'hFFFF_AABB, 1'b0, 11'h004, 3, 0);
    run_load(32'h12, 3'b010, 32'h0000_8899, 1'b0, 11'h004, 3, 0);
    run_load(32'h21, 3'b011, 32'h0000_0056, 1'b0, 11'h008, 3, 0);
    run_load(32'h22, 3'b001, 32'h0000_1234, 1'b0, 11'h008, 3, 0);
    run_load(32'h23, 3'b100, 32'h0000_0012, 1'b0, 11'h008, 3, 0);
    run_load(32'h22, 3'b011, 32'h0000_0034, 1'b0, 11'h008, 3, 0);

    // Misaligned and illegal types
    run_load(32'h11, 3'b001, 32'h0, 1'b1, 11'h000, 1, 0);
    run_load(32'h12, 3'b000, 32'h0, 1'b1, 11'h000, 1, 0);
    run_load(32'h10, 3'b111, 32'h0, 1'b1, 11'h000, 1, 0);
    run_load(32'h13, 3'b010, 32'h0, 1'b1, 11'h000, 1, 0);
    run_load(32'h00, 3'b101, 32'h0, 1'b1, 11'h000, 1, 2);

    // Back-pressure in RESP
    run_load(32'h20, 3'b000, 32'h1234_5678, 1'b0, 11'h008, 3, 5);

    // Reset during WAIT drops the access
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h10; req_type = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_en", 32'(o_mem_en), 32'd0);
    chk("mid_rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", o_rsp_data, 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_load(32'h13, 3'b100, 32'h0000_0088, 1'b0, 11'h004, 3, 0);

    // Read latency 3, top of the word space
    sel = 1'b1;
    run_load(32'h7FC, 3'b000, 32'hCAFE_F00D, 1'b0, 11'h1FF, 5, 0);
    run_load(32'h7FD, 3'b011, 32'hFFFF_FFF0, 1'b0, 11'h1FF, 5, 0);
    run_load(32'h7FE, 3'b010, 32'h0000_CAFE, 1'b0, 11'h1FF, 5, 0);
    run_load(32'h7FD, 3'b001, 32'h0, 1'b1, 11'h000, 1, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
